// File: rtl/ysyx_22050710_ifq_if.sv
// rtl/ysyx_22050710_ifq_if.sv - fetch/decode handshake bundle for the two-entry instruction queue
// master: fetch/decode/redirect side driving the queue; slave: the queue itself.
interface ysyx_22050710_ifq_if #(
   parameter int INST_WIDTH = 32,
   parameter int DATA_WIDTH = 64
);
   logic                  i_if_valid;
   logic [DATA_WIDTH-1:0] i_if_pc;
   logic [INST_WIDTH-1:0] i_if_inst;
   logic                  o_if_ready;
   logic                  o_id_valid;
   logic [DATA_WIDTH-1:0] o_id_pc;
   logic [INST_WIDTH-1:0] o_id_inst;
   logic                  i_id_ready;
   logic                  i_flush;
   logic [1:0]            o_count;

   modport master (
      output i_if_valid, i_if_pc, i_if_inst, i_id_ready, i_flush,
      input  o_if_ready, o_id_valid, o_id_pc, o_id_inst, o_count
   );

   modport slave (
      input  i_if_valid, i_if_pc, i_if_inst, i_id_ready, i_flush,
      output o_if_ready, o_id_valid, o_id_pc, o_id_inst, o_count
   );
endinterface

// File: rtl/ysyx_22050710_ifq.sv
// rtl/ysyx_22050710_ifq.sv - two-entry fetch-to-decode instruction queue with flush
// Optional YSYX_22050710_IFQ_BYPASS_EN: empty queue forwards fetch straight to decode.
module ysyx_22050710_ifq #(
   parameter int INST_WIDTH = 32,
   parameter int DATA_WIDTH = 64
) (
   input logic                     i_clk,
   input logic                     i_rst,
   ysyx_22050710_ifq_if.slave      q
);
   logic [DATA_WIDTH-1:0] pc_q   [2];
   logic [DATA_WIDTH-1:0] pc_d   [2];
   logic [INST_WIDTH-1:0] inst_q [2];
   logic [INST_WIDTH-1:0] inst_d [2];
   logic                  wp_q, wp_d;
   logic                  rp_q, rp_d;
   logic [1:0]            count_q, count_d;

   logic push;
   logic pop;
   logic pass;
   logic store;
   logic deq;
   logic bypass;

   // Ready depends only on registered occupancy so decode never reaches back into fetch.
   assign q.o_if_ready = (count_q != 2'd2);
   assign q.o_count    = count_q;

`ifdef YSYX_22050710_IFQ_BYPASS_EN
   assign bypass = (count_q == 2'd0) & q.i_if_valid & ~q.i_flush & ~i_rst;
`else
   assign bypass = 1'b0;
`endif

   always_comb begin
      q.o_id_valid = (count_q != 2'd0) | bypass;
      q.o_id_pc    = pc_q[rp_q];
      q.o_id_inst  = inst_q[rp_q];
      if (bypass) begin
         q.o_id_pc   = q.i_if_pc;
         q.o_id_inst = q.i_if_inst;
      end
   end

   assign push  = q.i_if_valid & q.o_if_ready & ~q.i_flush;
   assign pop   = q.o_id_valid & q.i_id_ready & ~q.i_flush;
   // A bypassed entry consumed in the same cycle never touches storage.
   assign pass  = bypass & q.i_id_ready;
   assign store = push & ~pass;
   assign deq   = pop & ~pass;

   always_comb begin
      pc_d    = pc_q;
      inst_d  = inst_q;
      wp_d    = wp_q;
      rp_d    = rp_q;
      count_d = count_q;
      if (q.i_flush) begin
         wp_d    = 1'b0;
         rp_d    = 1'b0;
         count_d = 2'd0;
      end else begin
         if (store) begin
            pc_d[wp_q]   = q.i_if_pc;
            inst_d[wp_q] = q.i_if_inst;
            wp_d         = ~wp_q;
         end
         if (deq) begin
            rp_d = ~rp_q;
         end
         unique case ({store, deq})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pc_q[0]   <= '0;
         pc_q[1]   <= '0;
         inst_q[0] <= '0;
         inst_q[1] <= '0;
         wp_q      <= 1'b0;
         rp_q      <= 1'b0;
         count_q   <= 2'd0;
      end else begin
         pc_q[0]   <= pc_d[0];
         pc_q[1]   <= pc_d[1];
         inst_q[0] <= inst_d[0];
         inst_q[1] <= inst_d[1];
         wp_q      <= wp_d;
         rp_q      <= rp_d;
         count_q   <= count_d;
      end
   end
endmodule
